vc_input_port: RTL and testbench

VC_INPUT_PORT -- requirements
Module: vc_input_port

---
 rtl/noc_params.sv | 43 ++++
 rtl/vc_buffer.sv | 136 +++++++++++++
 rtl/vc_input_port.sv | 116 +++++++++++
 tb/tb_vc_input_port.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_params.sv
// Shared NoC types: flit layout, flit labels, output ports and the per-VC packet state.
package noc_params;

    localparam int VC_NUM  = 4;
    localparam int VC_SIZE = $clog2(VC_NUM);
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VA     = 2'd1,
        ACTIVE = 2'd2
    } vc_state_t;

    typedef struct packed {
        flit_label_t         flit_label;
        logic [VC_SIZE-1:0]  vc_id;
        logic [DATA_W-1:0]   data;
    } flit_t;

    function automatic logic is_head(input flit_label_t label);
        return (label == HEAD) || (label == HEADTAIL);
    endfunction

    function automatic logic is_tail(input flit_label_t label);
        return (label == TAIL) || (label == HEADTAIL);
    endfunction

endpackage

// File: rtl/vc_buffer.sv
// One virtual channel: flit FIFO plus the head-of-line packet FSM (IDLE -> VA -> ACTIVE).
// Route and downstream VC are latched here so the port top only muxes buffer heads.
module vc_buffer
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = 8,
    parameter int DS_W        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  flit_t            flit_i,
    input  port_t            route_i,
    input  logic             rd_en_i,
    input  logic             va_valid_i,
    input  logic [DS_W-1:0]  va_new_vc_i,
    output flit_t            head_flit_o,
    output logic [DS_W-1:0]  downstream_vc_o,
    output logic             va_request_o,
    output logic             sa_request_o,
    output port_t            out_port_o,
    output logic             is_full_o,
    output logic             is_empty_o,
    output logic             pop_o,
    output logic             drop_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

    flit_t             flit_mem_q  [BUFFER_SIZE];
    port_t             route_mem_q [BUFFER_SIZE];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    vc_state_t         state_q, state_d;
    logic [DS_W-1:0]   ds_vc_q, ds_vc_d;
    port_t             out_port_q, out_port_d;
    logic              last_closed_q, last_closed_d;

    logic  empty, full, pop, push, in_head, reject;
    flit_t head_flit;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign head_flit = flit_mem_q[rd_ptr_q];
    assign pop       = rd_en_i && (state_q == ACTIVE) && !empty;
    assign in_head   = is_head(flit_i.flit_label);

    // last_closed_q tracks whether the most recently stored flit ended a packet,
    // so a new head is only accepted on a packet boundary.
    always_comb begin
        reject = 1'b0;
        if (full && !pop) begin
            reject = 1'b1;
        end
        if (in_head && !last_closed_q) begin
            reject = 1'b1;
        end
        if (!in_head && empty && (state_q == IDLE)) begin
            reject = 1'b1;
        end
    end

    assign push   = wr_en_i && !reject;
    assign drop_o = wr_en_i && reject;

    always_comb begin
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);
        count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
        last_closed_d = push ? is_tail(flit_i.flit_label) : last_closed_q;
        state_d       = state_q;
        ds_vc_d       = ds_vc_q;
        out_port_d    = out_port_q;
        case (state_q)
            IDLE: begin
                if (!empty && is_head(head_flit.flit_label)) begin
                    state_d    = VA;
                    out_port_d = route_mem_q[rd_ptr_q];
                end
            end
            VA: begin
                if (va_valid_i) begin
                    state_d = ACTIVE;
                    ds_vc_d = va_new_vc_i;
                end
            end
            ACTIVE: begin
                if (pop && is_tail(head_flit.flit_label)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            ds_vc_q       <= '0;
            out_port_q    <= LOCAL;
            last_closed_q <= 1'b1;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            ds_vc_q       <= ds_vc_d;
            out_port_q    <= out_port_d;
            last_closed_q <= last_closed_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            flit_mem_q[wr_ptr_q]  <= flit_i;
            route_mem_q[wr_ptr_q] <= route_i;
        end
    end

    assign head_flit_o     = head_flit;
    assign downstream_vc_o = ds_vc_q;
    assign va_request_o    = (state_q == VA);
    assign sa_request_o    = (state_q == ACTIVE) && !empty;
    assign out_port_o      = out_port_q;
    assign is_full_o       = full;
    assign is_empty_o      = empty;
    assign pop_o           = pop;

endmodule

// File: rtl/vc_input_port.sv
// Router input port: steers arriving flits into per-VC buffers and forwards the
// switch-allocated head flit to the crossbar, returning one credit per flit sent.
module vc_input_port #(
    parameter int  VC_NUM      = 4,
    parameter int  BUFFER_SIZE = 8,
    localparam int VC_SIZE     = $clog2(VC_NUM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  noc_params::flit_t                data_i,
    input  logic                             valid_flit_i,
    input  noc_params::port_t                route_i,
    input  logic [VC_NUM-1:0]                va_valid_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]   va_new_vc_i,
    input  logic                             sa_valid_i,
    input  logic [VC_SIZE-1:0]               sa_sel_vc_i,
    output noc_params::flit_t                xb_flit_o,
    output logic                             xb_valid_o,
    output logic                             credit_valid_o,
    output logic [VC_SIZE-1:0]               credit_vc_o,
    output logic [VC_NUM-1:0]                va_request_o,
    output logic [VC_NUM-1:0]                sa_request_o,
    output noc_params::port_t [VC_NUM-1:0]   out_port_o,
    output logic [VC_NUM-1:0]                is_full_o,
    output logic [VC_NUM-1:0]                is_empty_o,
    output logic                             error_o
);

    localparam int ID_W = noc_params::VC_SIZE;

    noc_params::flit_t   head_flit [VC_NUM];
    logic [VC_SIZE-1:0]  ds_vc     [VC_NUM];
    logic [VC_NUM-1:0]   wr_en, rd_en, pop, drop;
    logic                bad_wr_vc;

    noc_params::flit_t   xb_flit_q, xb_flit_d;
    logic                xb_valid_q, xb_valid_d;
    logic                credit_valid_q, credit_valid_d;
    logic [VC_SIZE-1:0]  credit_vc_q, credit_vc_d;
    logic                error_q, error_d;

    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            wr_en[v] = valid_flit_i && (data_i.vc_id == ID_W'(v));
            rd_en[v] = sa_valid_i && (sa_sel_vc_i == VC_SIZE'(v));
        end
    end

    assign bad_wr_vc = valid_flit_i && !(|wr_en);

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        vc_buffer #(
            .BUFFER_SIZE (BUFFER_SIZE),
            .DS_W        (VC_SIZE)
        ) u_vc_buffer (
            .clk             (clk),
            .rst             (rst),
            .wr_en_i         (wr_en[v]),
            .flit_i          (data_i),
            .route_i         (route_i),
            .rd_en_i         (rd_en[v]),
            .va_valid_i      (va_valid_i[v]),
            .va_new_vc_i     (va_new_vc_i[v]),
            .head_flit_o     (head_flit[v]),
            .downstream_vc_o (ds_vc[v]),
            .va_request_o    (va_request_o[v]),
            .sa_request_o    (sa_request_o[v]),
            .out_port_o      (out_port_o[v]),
            .is_full_o       (is_full_o[v]),
            .is_empty_o      (is_empty_o[v]),
            .pop_o           (pop[v]),
            .drop_o          (drop[v])
        );
    end

    // At most one VC pops per cycle, so an OR-mux over pop selects the granted head.
    always_comb begin
        xb_valid_d     = |pop;
        credit_valid_d = |pop;
        xb_flit_d      = '0;
        credit_vc_d    = credit_vc_q;
        for (int v = 0; v < VC_NUM; v++) begin
            if (pop[v]) begin
                xb_flit_d       = head_flit[v];
                xb_flit_d.vc_id = ID_W'(ds_vc[v]);
                credit_vc_d     = VC_SIZE'(v);
            end
        end
        error_d = error_q | (|drop) | bad_wr_vc | (sa_valid_i && !(|pop));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xb_flit_q      <= '0;
            xb_valid_q     <= 1'b0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            error_q        <= 1'b0;
        end else begin
            xb_flit_q      <= xb_flit_d;
            xb_valid_q     <= xb_valid_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
            error_q        <= error_d;
        end
    end

    assign xb_flit_o      = xb_flit_q;
    assign xb_valid_o     = xb_valid_q;
    assign credit_valid_o = credit_valid_q;
    assign credit_vc_o    = credit_vc_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_vc_input_port.sv
// Bench for vc_input_port (2 VCs x 4 flits): queue-based reference model checked every
// cycle, directed packet scenarios with literal expectations, then randomized traffic.
module tb_vc_input_port;
    import noc_params::*;

    localparam int NV = 2;
    localparam int BS = 4;

    typedef struct packed {
        flit_t f;
        port_t r;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    flit_t            data;
    logic             valid_flit;
    port_t            route;
    logic [1:0]       va_valid;
    logic [1:0][0:0]  va_new_vc;
    logic             sa_valid;
    logic [0:0]       sa_sel;
    flit_t            xb_flit;
    logic             xb_valid, credit_valid;
    logic [0:0]       credit_vc;
    logic [1:0]       va_req, sa_req, is_full, is_empty;
    port_t [1:0]      out_port;
    logic             error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vc_input_port #(.VC_NUM(NV), .BUFFER_SIZE(BS)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data),
        .valid_flit_i   (valid_flit),
        .route_i        (route),
        .va_valid_i     (va_valid),
        .va_new_vc_i    (va_new_vc),
        .sa_valid_i     (sa_valid),
        .sa_sel_vc_i    (sa_sel),
        .xb_flit_o      (xb_flit),
        .xb_valid_o     (xb_valid),
        .credit_valid_o (credit_valid),
        .credit_vc_o    (credit_vc),
        .va_request_o   (va_req),
        .sa_request_o   (sa_req),
        .out_port_o     (out_port),
        .is_full_o      (is_full),
        .is_empty_o     (is_empty),
        .error_o        (error)
    );

    // Reference model: per-VC queues, packet phase (0 idle, 1 awaiting VA, 2 active).
    ent_t       mq [NV][$];
    int         m_state [NV];
    logic [0:0] m_ds [NV];
    port_t      m_port [NV];
    bit         m_closed [NV];
    bit         m_err, m_xbv, m_cv;
    flit_t      m_xbf;
    logic [0:0] m_cvc;
    bit         open_pkt [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lbl_head(input flit_label_t l);
        return l == HEAD || l == HEADTAIL;
    endfunction

    function automatic bit lbl_tail(input flit_label_t l);
        return l == TAIL || l == HEADTAIL;
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            m_state[v]  = 0;
            m_ds[v]     = '0;
            m_port[v]   = LOCAL;
            m_closed[v] = 1'b1;
        end
        m_err = 0; m_xbv = 0; m_cv = 0; m_xbf = '0; m_cvc = '0;
    endfunction

    function automatic void model_step();
        int s;
        int v;
        bit pop;
        bit hd;
        int st_n [NV];
        ent_t e;
        if (rst) begin
            model_reset();
            return;
        end
        s = int'(sa_sel);
        pop = 0;
        if (sa_valid) begin
            if (m_state[s] == 2 && mq[s].size() > 0) pop = 1;
            else m_err = 1;
        end
        m_xbv = pop;
        m_cv  = pop;
        m_xbf = '0;
        if (pop) begin
            m_xbf = mq[s][0].f;
            m_xbf.vc_id = {1'b0, m_ds[s]};
            m_cvc = s[0:0];
        end
        for (int i = 0; i < NV; i++) begin
            st_n[i] = m_state[i];
            if (m_state[i] == 0) begin
                if (mq[i].size() > 0 && lbl_head(mq[i][0].f.flit_label)) begin
                    st_n[i] = 1;
                    m_port[i] = mq[i][0].r;
                end
            end else if (m_state[i] == 1) begin
                if (va_valid[i]) begin
                    st_n[i] = 2;
                    m_ds[i] = va_new_vc[i];
                end
            end else begin
                if (pop && s == i && lbl_tail(mq[i][0].f.flit_label)) st_n[i] = 0;
            end
        end
        if (valid_flit) begin
            v = int'(data.vc_id);
            if (v >= NV) begin
                m_err = 1;
            end else begin
                hd = lbl_head(data.flit_label);
                if ((mq[v].size() == BS && !(pop && s == v)) ||
                    (hd && !m_closed[v]) ||
                    (!hd && mq[v].size() == 0 && m_state[v] == 0)) begin
                    m_err = 1;
                end else begin
                    e.f = data;
                    e.r = route;
                    mq[v].push_back(e);
                    m_closed[v] = lbl_tail(data.flit_label);
                end
            end
        end
        if (pop) void'(mq[s].pop_front());
        for (int i = 0; i < NV; i++) m_state[i] = st_n[i];
    endfunction

    always @(negedge clk) begin : compare
        logic [1:0] e_va, e_sa, e_full, e_empty;
        for (int v = 0; v < NV; v++) begin
            e_va[v]    = (m_state[v] == 1);
            e_sa[v]    = (m_state[v] == 2) && (mq[v].size() > 0);
            e_full[v]  = (mq[v].size() == BS);
            e_empty[v] = (mq[v].size() == 0);
        end
        chk("va_request", 64'(va_req), 64'(e_va));
        chk("sa_request", 64'(sa_req), 64'(e_sa));
        chk("is_full", 64'(is_full), 64'(e_full));
        chk("is_empty", 64'(is_empty), 64'(e_empty));
        chk("out_port0", 64'(out_port[0]), 64'(m_port[0]));
        chk("out_port1", 64'(out_port[1]), 64'(m_port[1]));
        chk("error", 64'(error), 64'(m_err));
        chk("xb_valid", 64'(xb_valid), 64'(m_xbv));
        chk("credit_valid", 64'(credit_valid), 64'(m_cv));
        if (m_xbv) chk("xb_flit", 64'(xb_flit), 64'(m_xbf));
        if (m_cv) chk("credit_vc", 64'(credit_vc), 64'(m_cvc));
    end

    task automatic idle_in();
        valid_flit = 1'b0;
        data       = '0;
        route      = LOCAL;
        va_valid   = '0;
        va_new_vc  = '0;
        sa_valid   = 1'b0;
        sa_sel     = '0;
    endtask

    task automatic set_wr(input flit_label_t l, input int vc, input logic [15:0] d, input port_t r);
        valid_flit      = 1'b1;
        data.flit_label = l;
        data.vc_id      = 2'(vc);
        data.data       = d;
        route           = r;
    endtask

    task automatic set_sa(input int vc);
        sa_valid = 1'b1;
        sa_sel   = 1'(vc);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        idle_in();
    endtask

    task automatic rand_phase(input int n, input bit legal);
        for (int i = 0; i < n; i++) begin
            int cand [$];
            int v;
            flit_label_t l;
            if (legal) begin
                for (int c = 0; c < NV; c++)
                    if (m_state[c] == 2 && mq[c].size() > 0) cand.push_back(c);
                if (cand.size() > 0 && $urandom_range(0, 3) != 0)
                    set_sa(cand[$urandom_range(0, cand.size() - 1)]);
            end else if ($urandom_range(0, 3) == 0) begin
                set_sa($urandom_range(0, 1));
            end
            va_valid     = 2'($urandom);
            va_new_vc[0] = 1'($urandom_range(0, 1));
            va_new_vc[1] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                v = $urandom_range(0, 1);
                if (legal) begin
                    if (mq[v].size() < BS || (sa_valid && int'(sa_sel) == v)) begin
                        if (open_pkt[v]) l = ($urandom_range(0, 1) != 0) ? BODY : TAIL;
                        else             l = ($urandom_range(0, 1) != 0) ? HEAD : HEADTAIL;
                        set_wr(l, v, 16'($urandom), port_t'($urandom_range(0, 4)));
                        open_pkt[v] = (l == HEAD || l == BODY);
                    end
                end else begin
                    set_wr(flit_label_t'($urandom_range(0, 3)), v, 16'($urandom),
                           port_t'($urandom_range(0, 4)));
                end
            end
            step();
        end
    endtask

    initial begin
        idle_in();
        model_reset();
        repeat (3) step();
        chk("rst_xb_valid", 64'(xb_valid), 64'(0));
        chk("rst_xb_flit", 64'(xb_flit), 64'(0));
        chk("rst_credit_valid", 64'(credit_valid), 64'(0));
        chk("rst_credit_vc", 64'(credit_vc), 64'(0));
        chk("rst_va_request", 64'(va_req), 64'(0));
        chk("rst_sa_request", 64'(sa_req), 64'(0));
        chk("rst_out_port", 64'(out_port), 64'(0));
        chk("rst_is_full", 64'(is_full), 64'(0));
        chk("rst_is_empty", 64'(is_empty), 64'(2'b11));
        chk("rst_error", 64'(error), 64'(0));
        rst = 1'b0;

        // Three-flit packet on VC1 routed EAST, allocated to downstream VC0.
        set_wr(HEAD, 1, 16'h1001, EAST); step();
        set_wr(BODY, 1, 16'h1002, LOCAL); step();
        set_wr(TAIL, 1, 16'h1003, LOCAL); step();
        chk("a_va_request", 64'(va_req), 64'(2'b10));
        chk("a_out_port1", 64'(out_port[1]), 64'(EAST));
        va_valid = 2'b10; va_new_vc[1] = 1'b0; step();
        chk("a_sa_request", 64'(sa_req), 64'(2'b10));
        for (int k = 0; k < 3; k++) begin
            set_sa(1); step();
            chk("b_xb_valid", 64'(xb_valid), 64'(1));
            chk("b_xb_data", 64'(xb_flit.data), 64'(16'h1001 + k));
            chk("b_xb_vcid", 64'(xb_flit.vc_id), 64'(0));
            chk("b_credit_vc", 64'(credit_vc), 64'(1));
        end
        chk("b_va_request", 64'(va_req), 64'(0));
        chk("b_is_empty", 64'(is_empty), 64'(2'b11));

        // Fill VC0, then write and read together while full.
        set_wr(HEAD, 0, 16'h2001, SOUTH); step();
        for (int k = 2; k <= 4; k++) begin
            set_wr(BODY, 0, 16'h2000 + 16'(k), LOCAL); step();
        end
        chk("c_is_full", 64'(is_full), 64'(2'b01));
        va_valid = 2'b01; va_new_vc[0] = 1'b1; step();
        chk("c_sa_request", 64'(sa_req), 64'(2'b01));
        set_wr(BODY, 0, 16'h2005, LOCAL); set_sa(0); step();
        chk("c_full_rw", 64'(is_full), 64'(2'b01));
        chk("c_error", 64'(error), 64'(0));
        chk("c_xb_data", 64'(xb_flit.data), 64'(16'h2001));
        chk("c_xb_vcid", 64'(xb_flit.vc_id), 64'(1));

        // Overflow without read is dropped and latches the error.
        set_wr(BODY, 0, 16'h2006, LOCAL); step();
        chk("d_error", 64'(error), 64'(1));
        for (int k = 2; k <= 5; k++) begin
            set_sa(0); step();
            chk("d_xb_data", 64'(xb_flit.data), 64'(16'h2000 + k));
        end
        chk("d_is_empty", 64'(is_empty), 64'(2'b11));
        chk("d_sa_request", 64'(sa_req), 64'(0));
        chk("d_error_sticky", 64'(error), 64'(1));

        // HEADTAIL then HEAD on VC1.
        set_wr(HEADTAIL, 1, 16'h3001, NORTH); step();
        set_wr(HEAD, 1, 16'h3002, WEST); step();
        chk("e_va_request", 64'(va_req), 64'(2'b10));
        chk("e_out_port1", 64'(out_port[1]), 64'(NORTH));
        va_valid = 2'b10; va_new_vc[1] = 1'b1; step();
        set_sa(1); step();
        chk("e_xb_data", 64'(xb_flit.data), 64'(16'h3001));
        chk("e_va_idle", 64'(va_req), 64'(0));
        step();
        chk("e_va_again", 64'(va_req), 64'(2'b10));
        chk("e_out_port_new", 64'(out_port[1]), 64'(WEST));

        // Reset clears error; then reset mid-packet with a grant pending.
        rst = 1'b1; model_reset(); step();
        chk("f_error_clr", 64'(error), 64'(0));
        chk("f_out_port1", 64'(out_port[1]), 64'(LOCAL));
        rst = 1'b0;
        set_wr(HEAD, 0, 16'h4001, EAST); step();
        set_wr(BODY, 0, 16'h4002, LOCAL); step();
        set_wr(BODY, 0, 16'h4003, LOCAL); step();
        va_valid = 2'b01; step();
        rst = 1'b1; model_reset(); set_sa(0); step();
        chk("f_is_empty", 64'(is_empty), 64'(2'b11));
        chk("f_credit_valid", 64'(credit_valid), 64'(0));
        chk("f_xb_valid", 64'(xb_valid), 64'(0));
        chk("f_error", 64'(error), 64'(0));
        rst = 1'b0;

        for (int v = 0; v < NV; v++) open_pkt[v] = 1'b0;
        rand_phase(1000, 1'b1);
        chk("legal_traffic_error", 64'(error), 64'(0));

        rst = 1'b1; model_reset(); step(); rst = 1'b0;
        rand_phase(600, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
